// File: rtl/mmc3_mapper_ctrl.sv
// mmc3_mapper_ctrl: MMC3 (iNES mapper 004) register file, PRG/CHR bank
// translation, nametable mirroring and the A12-clocked scanline IRQ.
// ROM/RAM arrays live in the cart wrapper; this block only produces addresses.
module mmc3_mapper_ctrl #(
  parameter int PRG_ROM_DEPTH = 17,
  parameter int CHR_ROM_DEPTH = 17,
  parameter int A12_FILTER    = 3,
  parameter int IRQ_MODE      = 0
) (
  input  logic                     clk_cpu,
  input  logic                     rst_n,
  input  logic                     m2,
  input  logic [14:0]              cpu_addr,
  input  logic [7:0]               cpu_data_i,
  input  logic                     cpu_rw,
  input  logic                     romsel,
  output logic [PRG_ROM_DEPTH-1:0] prg_addr,
  output logic                     prg_ram_ce,
  output logic                     prg_ram_we,
  input  logic [13:0]              ppu_addr,
  output logic [CHR_ROM_DEPTH-1:0] chr_addr,
  output logic                     ciram_ce,
  output logic                     ciram_a10,
  output logic                     irq
);

  localparam int PRG_BW = PRG_ROM_DEPTH - 13;
  localparam int CHR_BW = CHR_ROM_DEPTH - 10;
  localparam int LOW_W  = $clog2(A12_FILTER + 2);
  localparam logic [LOW_W-1:0]  LOW_SAT  = LOW_W'(A12_FILTER);
  localparam logic [PRG_BW-1:0] PRG_LAST = {PRG_BW{1'b1}};
  localparam logic [PRG_BW-1:0] PRG_PREV = {{(PRG_BW-1){1'b1}}, 1'b0};

  // Register decode: {cpu_addr[14:13], cpu_addr[0]}.
  typedef enum logic [2:0] {
    REG_BANK_SEL   = 3'd0,  // $8000
    REG_BANK_DATA  = 3'd1,  // $8001
    REG_MIRROR     = 3'd2,  // $A000
    REG_RAM_CTL    = 3'd3,  // $A001
    REG_IRQ_LATCH  = 3'd4,  // $C000
    REG_IRQ_RELOAD = 3'd5,  // $C001
    REG_IRQ_DIS    = 3'd6,  // $E000
    REG_IRQ_EN     = 3'd7   // $E001
  } reg_sel_e;

  // Configuration state
  logic [7:0]       r_bank [8];
  logic [2:0]       r_index;
  logic             r_prg_mode, r_chr_inv, r_mirror, r_ram_en, r_ram_wp;
  // IRQ state
  logic [7:0]       r_irq_latch, r_counter;
  logic             r_reload, r_irq_en, r_pend;
  logic [LOW_W-1:0] r_lowcnt;
  logic             r_a12_q, r_m2;

  logic             w_m2_rise, w_wstb, w_reg_wr;
  reg_sel_e         w_reg_sel;
  logic             w_wr_reload, w_wr_irq_dis;
  logic             w_a12_rise, w_cnt_clk, w_pend_set;
  logic [7:0]       w_cnt_next;
  logic [PRG_BW-1:0] w_prg_bank;
  logic [CHR_BW-1:0] w_chr_bank;
  logic [2:0]       w_chr_slot;
  logic             w_ram_sel;

  assign w_m2_rise    = m2 & ~r_m2;
  assign w_wstb       = w_m2_rise & ~cpu_rw;
  assign w_reg_wr     = w_wstb & ~romsel;
  assign w_reg_sel    = reg_sel_e'({cpu_addr[14:13], cpu_addr[0]});
  assign w_wr_reload  = w_reg_wr && (w_reg_sel == REG_IRQ_RELOAD);
  assign w_wr_irq_dis = w_reg_wr && (w_reg_sel == REG_IRQ_DIS);

  // A $C001 write in the same cycle drops the counter clock entirely.
  assign w_a12_rise = ppu_addr[12] & ~r_a12_q;
  assign w_cnt_clk  = w_a12_rise && (r_lowcnt >= LOW_SAT) && !w_wr_reload;

  // Bank/mode/mirroring/RAM-control registers written by the CPU
  always_ff @(posedge clk_cpu) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      // NOTE: the eight bank registers form a small flop array, not a RAM macro, so resetting them is cheap and gives a known power-up map.
      for (int i = 0; i < 8; i++) r_bank[i] <= '0;
      r_index    <= '0;
      r_prg_mode <= 1'b0;
      r_chr_inv  <= 1'b0;
      r_mirror   <= 1'b0;
      r_ram_en   <= 1'b0;
      r_ram_wp   <= 1'b0;
    end else if (w_reg_wr) begin
      case (w_reg_sel)
        REG_BANK_SEL: begin
          r_index    <= cpu_data_i[2:0];
          r_prg_mode <= cpu_data_i[6];
          r_chr_inv  <= cpu_data_i[7];
        end
        REG_BANK_DATA: r_bank[r_index] <= cpu_data_i;
        REG_MIRROR:    r_mirror <= cpu_data_i[0];
        REG_RAM_CTL: begin
          r_ram_en <= cpu_data_i[7];
          r_ram_wp <= cpu_data_i[6];
        end
        default: ;
      endcase
    end
  end

  // Next counter value and pend-set condition for a counter clock
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    w_cnt_next = r_counter;
    w_pend_set = 1'b0;
    if (w_cnt_clk) begin
      if (r_counter == 8'd0 || r_reload) w_cnt_next = r_irq_latch;
      else                               w_cnt_next = r_counter - 8'd1;
      if (IRQ_MODE == 0)
        w_pend_set = (w_cnt_next == 8'd0) && r_irq_en;
      else
        w_pend_set = (w_cnt_next == 8'd0) && (r_counter != 8'd0 || r_reload) && r_irq_en;
    end
  end

  // Edge detectors, A12 low-time filter, scanline counter and IRQ pend
  always_ff @(posedge clk_cpu) begin
    if (!rst_n) begin
      r_m2        <= 1'b0;
      r_a12_q     <= 1'b0;
      r_lowcnt    <= '0;
      r_irq_latch <= '0;
      r_counter   <= '0;
      r_reload    <= 1'b0;
      r_irq_en    <= 1'b0;
      r_pend      <= 1'b0;
    end else begin
      r_m2    <= m2;
      r_a12_q <= ppu_addr[12];

      if (r_a12_q)                               r_lowcnt <= '0;
      else if (w_m2_rise && r_lowcnt < LOW_SAT)  r_lowcnt <= r_lowcnt + LOW_W'(1);

      if (w_reg_wr && w_reg_sel == REG_IRQ_LATCH) r_irq_latch <= cpu_data_i;

      if (w_wr_reload) begin
        r_counter <= '0;
        r_reload  <= 1'b1;
      end else if (w_cnt_clk) begin
        r_counter <= w_cnt_next;
        r_reload  <= 1'b0;
      end

      // Acknowledge beats a pend set in the same cycle.
      if (w_wr_irq_dis) begin
        r_irq_en <= 1'b0;
        r_pend   <= 1'b0;
      end else begin
        if (w_reg_wr && w_reg_sel == REG_IRQ_EN) r_irq_en <= 1'b1;
        if (w_pend_set)                          r_pend   <= 1'b1;
      end
    end
  end

  // PRG window -> 8 KB bank; the fixed windows point at the device's top banks
  always_comb begin
    case (cpu_addr[14:13])
      2'b00:   w_prg_bank = r_prg_mode ? PRG_PREV : r_bank[6][PRG_BW-1:0];
      2'b01:   w_prg_bank = r_bank[7][PRG_BW-1:0];
      2'b10:   w_prg_bank = r_prg_mode ? r_bank[6][PRG_BW-1:0] : PRG_PREV;
      default: w_prg_bank = PRG_LAST;
    endcase
  end

  // CHR 1 KB slot -> bank; slots 0-3 are two 2 KB pages built from R0/R1
  assign w_chr_slot = {ppu_addr[12] ^ r_chr_inv, ppu_addr[11:10]};
  always_comb begin
    case (w_chr_slot)
      3'd0, 3'd1: w_chr_bank = {r_bank[0][CHR_BW-1:1], ppu_addr[10]};
      3'd2, 3'd3: w_chr_bank = {r_bank[1][CHR_BW-1:1], ppu_addr[10]};
      3'd4:       w_chr_bank = r_bank[2][CHR_BW-1:0];
      3'd5:       w_chr_bank = r_bank[3][CHR_BW-1:0];
      3'd6:       w_chr_bank = r_bank[4][CHR_BW-1:0];
      default:    w_chr_bank = r_bank[5][CHR_BW-1:0];
    endcase
  end

  assign prg_addr   = {w_prg_bank, cpu_addr[12:0]};
  assign w_ram_sel  = romsel && (cpu_addr[14:13] == 2'b11);
  assign prg_ram_ce = w_ram_sel & r_ram_en;
  assign prg_ram_we = prg_ram_ce & ~cpu_rw & ~r_ram_wp;
  assign chr_addr   = {w_chr_bank, ppu_addr[9:0]};
  assign ciram_ce   = ~ppu_addr[13];
  assign ciram_a10  = r_mirror ? ppu_addr[11] : ppu_addr[10];
  assign irq        = r_pend;

endmodule

// File: tb/tb_mmc3_mapper_ctrl.sv
// tb_mmc3_mapper_ctrl: directed bench for mmc3_mapper_ctrl. Two instances
// (IRQ_MODE 0 and 1) share stimulus; a behavioural model predicts all outputs
// and is compared every cycle, with literal expectations pinning key points.
module tb_mmc3_mapper_ctrl;
  localparam int PRG_D = 17;
  localparam int CHR_D = 17;
  localparam int FILT  = 3;

  logic        clk_cpu = 1'b0;
  logic        rst_n, m2, cpu_rw, romsel;
  logic [14:0] cpu_addr;
  logic [7:0]  cpu_data_i;
  logic [13:0] ppu_addr;

  logic [PRG_D-1:0] prg_addr_0, prg_addr_1;
  logic [CHR_D-1:0] chr_addr_0, chr_addr_1;
  logic prg_ram_ce_0, prg_ram_ce_1, prg_ram_we_0, prg_ram_we_1;
  logic ciram_ce_0, ciram_ce_1, ciram_a10_0, ciram_a10_1, irq_0, irq_1;

  mmc3_mapper_ctrl #(.PRG_ROM_DEPTH(PRG_D), .CHR_ROM_DEPTH(CHR_D),
                     .A12_FILTER(FILT), .IRQ_MODE(0)) u_dut0 (
    .clk_cpu(clk_cpu), .rst_n(rst_n), .m2(m2), .cpu_addr(cpu_addr),
    .cpu_data_i(cpu_data_i), .cpu_rw(cpu_rw), .romsel(romsel),
    .prg_addr(prg_addr_0), .prg_ram_ce(prg_ram_ce_0), .prg_ram_we(prg_ram_we_0),
    .ppu_addr(ppu_addr), .chr_addr(chr_addr_0), .ciram_ce(ciram_ce_0),
    .ciram_a10(ciram_a10_0), .irq(irq_0));

  mmc3_mapper_ctrl #(.PRG_ROM_DEPTH(PRG_D), .CHR_ROM_DEPTH(CHR_D),
                     .A12_FILTER(FILT), .IRQ_MODE(1)) u_dut1 (
    .clk_cpu(clk_cpu), .rst_n(rst_n), .m2(m2), .cpu_addr(cpu_addr),
    .cpu_data_i(cpu_data_i), .cpu_rw(cpu_rw), .romsel(romsel),
    .prg_addr(prg_addr_1), .prg_ram_ce(prg_ram_ce_1), .prg_ram_we(prg_ram_we_1),
    .ppu_addr(ppu_addr), .chr_addr(chr_addr_1), .ciram_ce(ciram_ce_1),
    .ciram_a10(ciram_a10_1), .irq(irq_1));

  always #5 clk_cpu = ~clk_cpu;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Behavioural model state
  int m_bank[8];
  int m_index, m_latch, m_counter, m_low;
  bit m_mode, m_inv, m_mirror, m_ram_en, m_ram_wp, m_reload, m_irq_en;
  bit m_pend[2];
  bit m_m2_prev, m_a12_prev;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) m_bank[i] = 0;
    m_index = 0; m_latch = 0; m_counter = 0; m_low = 0;
    m_mode = 0; m_inv = 0; m_mirror = 0; m_ram_en = 0; m_ram_wp = 0;
    m_reload = 0; m_irq_en = 0; m_pend[0] = 0; m_pend[1] = 0;
    m_m2_prev = 0; m_a12_prev = 0;
  endfunction

  function automatic int exp_prg();
    int nb = 1 << (PRG_D - 13);
    int a  = int'(cpu_addr);
    int b;
    case (a / 8192)
      0:       b = m_mode ? nb - 2 : m_bank[6];
      1:       b = m_bank[7];
      2:       b = m_mode ? m_bank[6] : nb - 2;
      default: b = nb - 1;
    endcase
    return (b % nb) * 8192 + a % 8192;
  endfunction

  function automatic int exp_chr();
    int nb = 1 << (CHR_D - 10);
    int p  = int'(ppu_addr);
    int slot, b;
    slot = (((p / 4096) % 2) ^ int'(m_inv)) * 4 + (p / 1024) % 4;
    if (slot < 2)      b = m_bank[0] - m_bank[0] % 2 + (p / 1024) % 2;
    else if (slot < 4) b = m_bank[1] - m_bank[1] % 2 + (p / 1024) % 2;
    else               b = m_bank[slot - 2];
    return (b % nb) * 1024 + p % 1024;
  endfunction

  function automatic bit exp_ram_ce();
    return romsel && (int'(cpu_addr) / 8192 == 3) && m_ram_en;
  endfunction

  // Advance the model over one clock edge using the inputs now applied.
  task automatic model_step();
    bit m2_rise, wr, a12_rise, clocked, old_reload;
    int sel, old_cnt, new_cnt;
    if (!rst_n) begin
      model_reset();
    end else begin
      m2_rise  = m2 && !m_m2_prev;
      wr       = m2_rise && !cpu_rw && !romsel;
      sel      = wr ? (int'(cpu_addr) / 8192) * 2 + int'(cpu_addr) % 2 : -1;
      a12_rise = ppu_addr[12] && !m_a12_prev;
      clocked  = a12_rise && (m_low >= FILT) && (sel != 5);
      if (clocked) begin
        old_cnt    = m_counter;
        old_reload = m_reload;
        new_cnt    = (old_cnt == 0 || old_reload) ? m_latch : old_cnt - 1;
        m_counter  = new_cnt;
        m_reload   = 0;
        if (new_cnt == 0 && m_irq_en) begin
          m_pend[0] = 1;
          if (old_cnt != 0 || old_reload) m_pend[1] = 1;
        end
      end
      case (sel)
        0: begin m_index = int'(cpu_data_i[2:0]); m_mode = cpu_data_i[6]; m_inv = cpu_data_i[7]; end
        1: m_bank[m_index] = int'(cpu_data_i);
        2: m_mirror = cpu_data_i[0];
        3: begin m_ram_en = cpu_data_i[7]; m_ram_wp = cpu_data_i[6]; end
        4: m_latch = int'(cpu_data_i);
        5: begin m_counter = 0; m_reload = 1; end
        6: begin m_irq_en = 0; m_pend[0] = 0; m_pend[1] = 0; end
        7: m_irq_en = 1;
        default: ;
      endcase
      if (m_a12_prev)                   m_low = 0;
      else if (m2_rise && m_low < FILT) m_low++;
      m_m2_prev  = m2;
      m_a12_prev = ppu_addr[12];
    end
  endtask

  // Every-cycle comparison of both instances against the model
  always @(negedge clk_cpu) begin
    if (chk_en) begin
      check("prg_addr0",  prg_addr_0,   exp_prg());
      check("prg_addr1",  prg_addr_1,   exp_prg());
      check("chr_addr0",  chr_addr_0,   exp_chr());
      check("chr_addr1",  chr_addr_1,   exp_chr());
      check("ram_ce0",    prg_ram_ce_0, exp_ram_ce());
      check("ram_ce1",    prg_ram_ce_1, exp_ram_ce());
      check("ram_we0",    prg_ram_we_0, exp_ram_ce() && !cpu_rw && !m_ram_wp);
      check("ram_we1",    prg_ram_we_1, exp_ram_ce() && !cpu_rw && !m_ram_wp);
      check("ciram_ce0",  ciram_ce_0,   !ppu_addr[13]);
      check("ciram_ce1",  ciram_ce_1,   !ppu_addr[13]);
      check("ciram_a10_0", ciram_a10_0, m_mirror ? ppu_addr[11] : ppu_addr[10]);
      check("ciram_a10_1", ciram_a10_1, m_mirror ? ppu_addr[11] : ppu_addr[10]);
      check("irq0",       irq_0,        m_pend[0]);
      check("irq1",       irq_1,        m_pend[1]);
    end
  end

  // One clock: outputs compared at negedge, model updated, then past posedge.
  task automatic tick();
    @(negedge clk_cpu);
    #1;
    model_step();
    @(posedge clk_cpu);
    #1;
  endtask

  task automatic cpu_write_x(input int a, input int d, input bit a12_hit);
    romsel = (a >= 'h8000) ? 1'b0 : 1'b1;
    cpu_addr = a[14:0];
    cpu_data_i = d[7:0];
    cpu_rw = 1'b0;
    m2 = 1'b0;
    tick();
    m2 = 1'b1;
    if (a12_hit) ppu_addr = 14'h1000;
    tick();
    m2 = 1'b0;
    cpu_rw = 1'b1;
    romsel = 1'b1;
    ppu_addr = 14'h0000;
    tick();
  endtask

  task automatic cpu_write(input int a, input int d);
    cpu_write_x(a, d, 1'b0);
  endtask

  task automatic m2_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      m2 = 1'b1; tick();
      m2 = 1'b0; tick();
    end
  endtask

  // One-cycle A12 high pulse; irq is checked the cycle after the rise.
  task automatic a12_pulse(input string name, input bit e0, input bit e1);
    ppu_addr = 14'h1000;
    tick();
    check({name, "_irq0"}, irq_0, e0);
    check({name, "_irq1"}, irq_1, e1);
    ppu_addr = 14'h0000;
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; m2 = 1'b0; cpu_rw = 1'b1; romsel = 1'b1;
    cpu_addr = '0; cpu_data_i = '0; ppu_addr = '0;
    tick(); tick();
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Reset values
    romsel = 1'b0; cpu_addr = 15'h6000; #2;
    check("rst_prg_e000", prg_addr_0, 32'h1E000);
    cpu_addr = 15'h4000; #2;
    check("rst_prg_c000", prg_addr_0, 32'h1C000);
    check("rst_irq0", irq_0, 0);
    check("rst_irq1", irq_1, 0);
    romsel = 1'b1; cpu_addr = 15'h6000; cpu_rw = 1'b0; #2;
    check("rst_ram_ce", prg_ram_ce_0, 0);
    cpu_rw = 1'b1;
    tick();

    // PRG mode switch and bank truncation
    cpu_write('h8000, 'h06);
    cpu_write('h8001, 'h03);
    cpu_write('h8000, 'h46);
    romsel = 1'b0; cpu_addr = 15'h0000; #2;
    check("prg_m1_8000", prg_addr_0, 32'h1C000);
    cpu_addr = 15'h4123; #2;
    check("prg_m1_c000", prg_addr_0, 32'h06123);
    romsel = 1'b1;
    cpu_write('h8000, 'h47);
    cpu_write('h8001, 'h25);
    romsel = 1'b0; cpu_addr = 15'h2ABC; #2;
    check("prg_r7_trunc", prg_addr_0, 32'h0AABC);
    romsel = 1'b1;
    tick();

    // CHR inversion: R0=5, R2=9, chr_inv=1
    cpu_write('h8000, 'h80);
    cpu_write('h8001, 'h05);
    cpu_write('h8000, 'h82);
    cpu_write('h8001, 'h09);
    ppu_addr = 14'h1400; #2;
    check("chr_inv_1400", chr_addr_0, 32'h01400);
    ppu_addr = 14'h0000; #2;
    check("chr_inv_0000", chr_addr_0, 32'h02400);
    ppu_addr = 14'h1000; #2;
    check("chr_inv_1000", chr_addr_0, 32'h01000);
    ppu_addr = 14'h0000;
    tick();

    // Mirroring and PRG RAM control
    cpu_write('hA000, 'h01);
    ppu_addr = 14'h2800; #2;
    check("ntab_a10_h", ciram_a10_0, 1);
    check("ntab_ce", ciram_ce_0, 0);
    ppu_addr = 14'h2400; #2;
    check("ntab_a10_l", ciram_a10_0, 0);
    ppu_addr = 14'h0000;
    tick();
    cpu_write('hA001, 'h80);
    cpu_addr = 15'h6000; cpu_rw = 1'b0; #2;
    check("ram_ce_en", prg_ram_ce_0, 1);
    check("ram_we_en", prg_ram_we_0, 1);
    cpu_rw = 1'b1;
    cpu_write('hA001, 'hC0);
    cpu_addr = 15'h6000; cpu_rw = 1'b0; #2;
    check("ram_we_wp", prg_ram_we_0, 0);
    cpu_rw = 1'b1;
    tick();

    // A12 filter and counting: latch=2
    cpu_write('hC000, 'h02);
    cpu_write('hE001, 'h00);
    a12_pulse("flt_load", 0, 0);
    cpu_write('hC001, 'h00);
    a12_pulse("flt_short", 0, 0);
    m2_pulses(3); a12_pulse("flt_cnt2", 0, 0);
    m2_pulses(3); a12_pulse("flt_cnt1", 0, 0);
    m2_pulses(3); a12_pulse("flt_cnt0", 1, 1);
    cpu_write('hE000, 'h00);
    check("ack_irq0", irq_0, 0);
    check("ack_irq1", irq_1, 0);
    cpu_write('hE001, 'h00);

    // IRQ_MODE comparison with latch=0
    cpu_write('hC000, 'h00);
    cpu_write('hC001, 'h00);
    m2_pulses(3); a12_pulse("mode_reload", 1, 1);
    for (int k = 0; k < 2; k++) begin
      cpu_write('hE000, 'h00);
      cpu_write('hE001, 'h00);
      m2_pulses(3); a12_pulse("mode_repeat", 1, 0);
    end

    // $C001 colliding with a counter clock: write wins
    cpu_write('hE000, 'h00);
    cpu_write('hE001, 'h00);
    cpu_write('hC000, 'h01);
    m2_pulses(3); a12_pulse("col_load1", 0, 0);
    m2_pulses(3);
    cpu_write_x('hC001, 'h00, 1'b1);
    check("col_c001_irq0", irq_0, 0);
    check("col_c001_irq1", irq_1, 0);
    m2_pulses(3); a12_pulse("col_reload", 0, 0);
    m2_pulses(3); a12_pulse("col_dec0", 1, 1);

    // $E000 colliding with a pend-setting clock: clear wins
    cpu_write('hE000, 'h00);
    cpu_write('hE001, 'h00);
    m2_pulses(3); a12_pulse("col_load2", 0, 0);
    m2_pulses(3);
    cpu_write_x('hE000, 'h00, 1'b1);
    check("col_e000_irq0", irq_0, 0);
    check("col_e000_irq1", irq_1, 0);

    // Reset mid-operation drops a pending IRQ
    cpu_write('hE001, 'h00);
    cpu_write('hC000, 'h00);
    m2_pulses(3); a12_pulse("pre_rst", 1, 0);
    rst_n = 1'b0;
    tick();
    check("midrst_irq0", irq_0, 0);
    rst_n = 1'b1;
    romsel = 1'b0; cpu_addr = 15'h0000; #2;
    check("midrst_prg", prg_addr_0, 32'h00000);
    romsel = 1'b1;
    tick(); tick();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
